btn_evt_ctrl: RTL and testbench

BTN_EVT_CTRL -- requirements
Module: btn_evt_ctrl

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/btn_evt_ctrl.sv | 124 ++++++++++++
 tb/tb_btn_evt_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button event controller: register map,
// register index enum and the debounce counter width helper.
// No ports; imported by btn_debounce and btn_evt_ctrl.
package btn_pkg;

  // Byte offsets of the registers.
  localparam logic [7:0] ADR_STATE = 8'h00;
  localparam logic [7:0] ADR_COL   = 8'h04;
  localparam logic [7:0] ADR_MIS   = 8'h08;
  localparam logic [7:0] ADR_PEND  = 8'h0C;
  localparam logic [7:0] ADR_IE    = 8'h10;

  // Word index as decoded from adr[7:2].
  typedef enum logic [5:0] {
    REG_STATE = 6'd0,
    REG_COL   = 6'd1,
    REG_MIS   = 6'd2,
    REG_PEND  = 6'd3,
    REG_IE    = 6'd4
  } reg_idx_e;

  // Width needed to hold the values 0..cycles.
  function automatic int db_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, stable state
// and a single-cycle rise pulse on a debounced 0->1 change.
// Ports: btn_clk_i/btn_rst_i, btn_raw (async input), btn_stable, btn_rise.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic btn_clk_i,
  input  logic btn_rst_i,
  input  logic btn_raw,
  output logic btn_stable,
  output logic btn_rise
);

  localparam int CNT_W = db_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES);

  logic             sync_q0;
  logic             sync_q1;
  logic [CNT_W-1:0] cnt_q;
  logic             flip;

  // The counter holds how many consecutive clocks the synchronized input has
  // already differed; this clock is the DB_CYCLES-th one when it reads
  // DB_CYCLES-1, so the state flips on that edge.
  assign flip      = (sync_q1 != btn_stable) && (cnt_q >= CNT_LAST);
  assign btn_rise  = flip & sync_q1;

  always_ff @(posedge btn_clk_i or posedge btn_rst_i) begin
    if (btn_rst_i) begin
      sync_q0    <= 1'b0;
      sync_q1    <= 1'b0;
      cnt_q      <= '0;
      btn_stable <= 1'b0;
    end else begin
      sync_q0 <= btn_raw;
      sync_q1 <= sync_q0;
      if (sync_q1 == btn_stable) begin
        cnt_q <= '0;
      end else if (flip) begin
        btn_stable <= sync_q1;
        cnt_q      <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_evt_ctrl.sv
// Debounced button event controller with a small bus register file:
// STATE (RO), COL (RW), MIS (RW), PEND (W1C, sticky rise events), IE (RW).
// Ports: bus slave (cyc/stb/we/adr/dat/sel -> dat/ack/err), btn_inta_o level
// interrupt, raw btn_data inputs, btn_col_o and btn_missle_en outputs.
module btn_evt_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN     = 5,
  parameter int DB_CYCLES = 500000,
  parameter int COL_W     = 12,
  parameter int COL_RST   = 312,
  parameter int N_MIS     = 8
) (
  input  logic             btn_clk_i,
  input  logic             btn_rst_i,
  input  logic             btn_m2s_cyc_i,
  input  logic             btn_m2s_stb_i,
  input  logic             btn_m2s_we_i,
  input  logic [7:0]       btn_m2s_adr_i,
  input  logic [31:0]      btn_m2s_dat_i,
  input  logic [3:0]       btn_sel_i,
  output logic [31:0]      btn_s2m_dat_o,
  output logic             btn_s2m_ack_o,
  output logic             btn_s2m_err_o,
  output logic             btn_inta_o,
  input  logic [N_BTN-1:0] btn_data,
  output logic [COL_W-1:0] btn_col_o,
  output logic [N_MIS-1:0] btn_missle_en
);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pend_q;
  logic [N_BTN-1:0] ie_q;
  logic [N_BTN-1:0] w1c;
  logic [COL_W-1:0] col_q;
  logic [N_MIS-1:0] mis_q;
  logic             ack_q;
  logic             err_q;
  logic             req;
  logic             mapped;
  logic             wr_en;
  logic [5:0]       reg_idx;
  logic [31:0]      rdata;
  logic             unused_bits;

  // Byte selects and the low address bits play no part: full-word access only.
  assign unused_bits = ^{btn_sel_i, btn_m2s_adr_i[1:0], btn_m2s_dat_i};

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .btn_clk_i (btn_clk_i),
      .btn_rst_i (btn_rst_i),
      .btn_raw   (btn_data[i]),
      .btn_stable(stable[i]),
      .btn_rise  (rise[i])
    );
  end

  assign req     = btn_m2s_cyc_i & btn_m2s_stb_i;
  assign reg_idx = btn_m2s_adr_i[7:2];
  assign mapped  = (reg_idx <= REG_IE);

  // Response flops only rise from an idle cycle, so a held request sees a
  // wait state between consecutive responses.
  always_ff @(posedge btn_clk_i or posedge btn_rst_i) begin
    if (btn_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= req & ~(ack_q | err_q) & mapped;
      err_q <= req & ~(ack_q | err_q) & ~mapped;
    end
  end

  // Gating with the live request drops a cycle whose strobe went away early.
  assign btn_s2m_ack_o = ack_q & req;
  assign btn_s2m_err_o = err_q & req;
  assign wr_en         = btn_s2m_ack_o & btn_m2s_we_i;

  assign w1c = (wr_en && reg_idx == REG_PEND) ? btn_m2s_dat_i[N_BTN-1:0] : '0;

  always_ff @(posedge btn_clk_i or posedge btn_rst_i) begin
    if (btn_rst_i) begin
      col_q  <= COL_W'(COL_RST);
      mis_q  <= '0;
      ie_q   <= '0;
      pend_q <= '0;
    end else begin
      // New rise events win over a clear of the same bit.
      pend_q <= (pend_q & ~w1c) | rise;
      if (wr_en) begin
        case (reg_idx)
          REG_COL: col_q <= btn_m2s_dat_i[COL_W-1:0];
          REG_MIS: mis_q <= btn_m2s_dat_i[N_MIS-1:0];
          REG_IE:  ie_q  <= btn_m2s_dat_i[N_BTN-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (btn_s2m_ack_o) begin
      case (reg_idx)
        REG_STATE: rdata[N_BTN-1:0] = stable;
        REG_COL:   rdata[COL_W-1:0] = col_q;
        REG_MIS:   rdata[N_MIS-1:0] = mis_q;
        REG_PEND:  rdata[N_BTN-1:0] = pend_q;
        REG_IE:    rdata[N_BTN-1:0] = ie_q;
        default:   ;
      endcase
    end
  end

  assign btn_s2m_dat_o = rdata;
  assign btn_inta_o    = |(pend_q & ie_q);
  assign btn_col_o     = col_q;
  assign btn_missle_en = mis_q;

endmodule

// File: tb/tb_btn_evt_ctrl.sv
module tb_btn_evt_ctrl;
  import btn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [7:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack, err, inta;
  logic [4:0]  btn;
  logic [11:0] col;
  logic [7:0]  mis;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  btn_evt_ctrl #(
    .N_BTN(5), .DB_CYCLES(4), .COL_W(12), .COL_RST(312), .N_MIS(8)
  ) dut (
    .btn_clk_i    (clk),
    .btn_rst_i    (rst),
    .btn_m2s_cyc_i(cyc),
    .btn_m2s_stb_i(stb),
    .btn_m2s_we_i (we),
    .btn_m2s_adr_i(adr),
    .btn_m2s_dat_i(wdat),
    .btn_sel_i    (sel),
    .btn_s2m_dat_o(rdat),
    .btn_s2m_ack_o(ack),
    .btn_s2m_err_o(err),
    .btn_inta_o   (inta),
    .btn_data     (btn),
    .btn_col_o    (col),
    .btn_missle_en(mis)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a clock edge. Holds the request through the
  // response cycle, then releases it.
  task automatic bus(input string tag, input logic w, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    exp_t r;
    bit   got;
    e.dat = exp_rd;
    e.err = exp_err;
    exp_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = wd;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack || err) got = 1'b1;
    end
    r = exp_q.pop_front();
    check({tag, "_resp"}, 32'(got), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(r.err));
    check({tag, "_ack"}, 32'(ack), 32'(!r.err));
    if (!w) check({tag, "_dat"}, rdat, r.dat);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = 4'hF; btn = '0;
    #13;
    check("rst_col", 32'(col), 32'd312);
    check("rst_mis", 32'(mis), 32'd0);
    check("rst_inta", 32'(inta), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    // Steady press on channel 2: stable exactly 6 clocks after the change.
    btn[2] = 1'b1;
    tick(4);
    bus("state_early", 1'b0, ADR_STATE, 0, 32'h0, 1'b0);
    bus("state_set", 1'b0, ADR_STATE, 0, 32'h4, 1'b0);
    bus("pend_set", 1'b0, ADR_PEND, 0, 32'h4, 1'b0);
    check("inta_ie0", 32'(inta), 32'd0);

    // Bouncing channel 0 never holds long enough to flip.
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      tick(3);
    end
    tick(6);
    bus("state_bounce", 1'b0, ADR_STATE, 0, 32'h4, 1'b0);
    bus("pend_bounce", 1'b0, ADR_PEND, 0, 32'h4, 1'b0);

    // Clear, enable interrupts, press channel 1.
    bus("pend_clr", 1'b1, ADR_PEND, 32'h4, 0, 1'b0);
    bus("pend_zero", 1'b0, ADR_PEND, 0, 32'h0, 1'b0);
    bus("ie_wr", 1'b1, ADR_IE, 32'h1F, 0, 1'b0);
    bus("ie_rd", 1'b0, ADR_IE, 0, 32'h1F, 1'b0);
    check("inta_none", 32'(inta), 32'd0);
    btn[1] = 1'b1;
    tick(8);
    check("inta_press", 32'(inta), 32'd1);
    bus("pend_b1", 1'b0, ADR_PEND, 0, 32'h2, 1'b0);
    bus("pend_clr1", 1'b1, ADR_PEND, 32'h2, 0, 1'b0);
    check("inta_clr", 32'(inta), 32'd0);

    // Release sets nothing.
    btn[1] = 1'b0;
    tick(10);
    bus("pend_release", 1'b0, ADR_PEND, 0, 32'h0, 1'b0);

    // Press again so the rise lands on the same edge as the clear.
    btn[1] = 1'b1;
    tick(4);
    bus("pend_race_clr", 1'b1, ADR_PEND, 32'h2, 0, 1'b0);
    bus("pend_race", 1'b0, ADR_PEND, 0, 32'h2, 1'b0);
    check("inta_race", 32'(inta), 32'd1);

    // Two channels rising together.
    bus("pend_clr_all", 1'b1, ADR_PEND, 32'h1F, 0, 1'b0);
    btn[3] = 1'b1; btn[4] = 1'b1;
    tick(8);
    bus("pend_multi", 1'b0, ADR_PEND, 0, 32'h18, 1'b0);
    bus("state_multi", 1'b0, ADR_STATE, 0, 32'h1E, 1'b0);

    // STATE is read-only.
    bus("state_wr", 1'b1, ADR_STATE, 32'h0, 0, 1'b0);
    bus("state_keep", 1'b0, ADR_STATE, 0, 32'h1E, 1'b0);

    // COL / MIS registers.
    bus("col_wr", 1'b1, ADR_COL, 32'hFFFF_F0A0, 0, 1'b0);
    bus("col_rd", 1'b0, ADR_COL, 0, 32'h0A0, 1'b0);
    check("col_out", 32'(col), 32'h0A0);
    bus("mis_wr", 1'b1, ADR_MIS, 32'h5A, 0, 1'b0);
    bus("mis_rd", 1'b0, ADR_MIS, 0, 32'h5A, 1'b0);
    check("mis_out", 32'(mis), 32'h5A);

    // Strobe held across four cycles: ack 0,1,0,1.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = ADR_MIS;
    check("b2b_ack0", 32'(ack), 32'd0);
    tick(1);
    check("b2b_ack1", 32'(ack), 32'd1);
    check("b2b_dat1", rdat, 32'h5A);
    tick(1);
    check("b2b_ack2", 32'(ack), 32'd0);
    tick(1);
    check("b2b_ack3", 32'(ack), 32'd1);
    tick(1);
    cyc = 1'b0; stb = 1'b0;
    tick(1);

    // Unmapped accesses.
    bus("unmapped_rd", 1'b0, 8'h40, 0, 32'h0, 1'b1);
    bus("unmapped_wr", 1'b1, 8'h14, 32'hFF, 0, 1'b1);
    bus("mis_after_err", 1'b0, ADR_MIS, 0, 32'h5A, 1'b0);

    // Reset restores COL and clears MIS / interrupt.
    rst = 1'b1;
    #1;
    check("rst2_col", 32'(col), 32'd312);
    check("rst2_mis", 32'(mis), 32'd0);
    check("rst2_inta", 32'(inta), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);

    // Reset in the middle of a write: no ack and no write.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = ADR_MIS; wdat = 32'hFF;
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ack0", 32'(ack), 32'd0);
    @(posedge clk); #1;
    check("abort_ack1", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    tick(1);
    check("abort_mis_out", 32'(mis), 32'd0);
    bus("abort_mis", 1'b0, ADR_MIS, 0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
